rv32i_irq_ctrl: RTL and testbench
=================================

// Module: rv32i_irq_ctrl
// PURPOSE
//   Memory-mapped interrupt aggregator that drives rv32i_soc i_external_interrupt and i_software_interrupt.
//   - Synchronizes NUM_SRC asynchronous peripheral lines and latches their rising edges as pending bits.
//   - Masks pending bits with an enable register and exposes a claim register.
//   - Holds an MSIP bit for software interrupts.
//   - Slaves on the core data bus: single-beat request, one-cycle-later ack.
// PARAMETERS
//   NUM_SRC      8   number of interrupt sources, 1..31
//   SYNC_STAGES  2   synchronizer flops per source, >=2
// PORTS
//   i_clk                 in   1        core clock
//   i_rst_n               in   1        synchronous active-low reset
//   i_irq_src             in   NUM_SRC  async interrupt lines from peripherals
//   i_stb                 in   1        bus request strobe
//   i_wr_en               in   1        1 = write, 0 = read (valid with i_stb)
//   i_addr                in   4        byte offset, word aligned ([1:0] ignored)
//   i_wdata               in   32       write data
//   o_rdata               out  32       read data, valid with o_ack
//   o_ack                 out  1        one-cycle completion pulse
//   o_external_interrupt  out  1        to core i_external_interrupt
//   o_software_interrupt  out  1        to core i_software_interrupt
// BEHAVIOUR
//   Reset (i_clk edge with i_rst_n=0): sync chains, edge history, PENDING, ENABLE, MSIP, o_rdata, o_ack,
//     both irq outputs -> 0. Reset mid-transaction drops that transaction; no ack is issued.
//   Register map:
//     0x0 PENDING  RO, W1C   bit n = latched edge of source n
//     0x4 ENABLE   RW        bits above NUM_SRC-1 read 0
//     0x8 CLAIM    RO        read returns k+1, where k = lowest index with PENDING&ENABLE set;
//                            same-cycle side effect clears PENDING[k]; returns 0 (no side effect) when none
//     0xC MSIP     RW        bit0 only; others read 0
//     Unmapped offsets: reads 0, writes ignored, still acked. Writes to CLAIM are ignored.
//   Bus FSM, 2 states:
//     IDLE -(i_stb)-> ACK: capture the request; perform the write or read side effect; register o_rdata.
//     ACK: o_ack=1 for exactly one cycle, then -> IDLE. i_stb seen in ACK is ignored.
//     Minimum throughput: 1 transaction per 2 cycles.
//   Source path:
//     - Async line passes through the SYNC_STAGES flop chain.
//     - A rising edge (sync=1, previous=0) sets PENDING[n].
//     - Edge at cycle 0 -> PENDING set at cycle SYNC_STAGES+1.
//   Simultaneous events: a set and a clear (W1C or claim) on the same bit in the same cycle -> set wins.
//   o_external_interrupt: registered |(PENDING & ENABLE), one cycle after PENDING changes.
//   o_software_interrupt: registered MSIP[0].
//   Width rules: PENDING/ENABLE are NUM_SRC bits, zero-extended to 32 on read. CLAIM is a 5-bit index,
//     zero-extended.
// CONFIGURATION
//   IRQ_LEVEL_MODE_EN defined:
//     - PENDING[n] = synchronized level of source n each cycle (no latch, no edge detect).
//     - W1C and claim do not modify PENDING; a claim read still returns k+1.
//     - Assertion latency is SYNC_STAGES cycles.
//   IRQ_LEVEL_MODE_EN undefined: edge-latched behaviour as described above.
// TESTING
//   1. Reset, then read 0x0/0x4/0x8/0xC -> all 0x00000000; both irq outputs 0; o_ack pulses once per read.
//   2. Write ENABLE=0x04; pulse i_irq_src[2] for 1 cycle -> PENDING=0x04 at cycle SYNC_STAGES+1;
//      o_external_interrupt=1 one cycle later.
//   3. Sources 5 and 2 pending and enabled; read CLAIM -> 0x3; then PENDING=0x20; next CLAIM read -> 0x6;
//      external irq then drops to 0.
//   4. Source 1 pending with ENABLE=0 -> no external irq; write ENABLE=0x02 -> irq asserts 1 cycle later;
//      write PENDING=0x02 (W1C) -> PENDING=0, irq deasserts.
//   5. W1C to bit 3 in the same cycle a synchronized edge sets bit 3 -> PENDING[3] stays 1.
//   6. Write MSIP=1 -> o_software_interrupt=1 after the write cycle; assert i_rst_n=0 mid-transaction ->
//      all outputs 0, no o_ack.

Source files
------------

// File: rtl/rv32i_irq_ctrl.sv
// rv32i_irq_ctrl -- memory-mapped interrupt aggregator for rv32i_soc.
//
// Collects NUM_SRC asynchronous peripheral interrupt lines into a PENDING
// register, masks them with ENABLE and drives the core external interrupt
// input. A claim register returns the lowest enabled pending source (index+1)
// and acknowledges it in the same access. An MSIP bit drives the core software
// interrupt. The bus slave accepts one single-beat request and acknowledges it
// on the following cycle.
//
// Register map (byte offsets, addr[1:0] ignored):
//   0x0 PENDING  RO, write-1-to-clear
//   0x4 ENABLE   RW, NUM_SRC bits
//   0x8 CLAIM    RO, returns k+1 for lowest pending&enabled k, clears it
//   0xC MSIP     RW, bit 0 only
//
// Build option:
//   IRQ_LEVEL_MODE_EN -- PENDING follows the synchronized source levels
//                        directly (no edge latch); W1C and claim do not
//                        modify PENDING. Undefined: rising edges are latched.

module rv32i_irq_ctrl #(
  parameter int NUM_SRC     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_SRC-1:0] i_irq_src,
  input  logic               i_stb,
  input  logic               i_wr_en,
  input  logic [3:0]         i_addr,
  input  logic [31:0]        i_wdata,
  output logic [31:0]        o_rdata,
  output logic               o_ack,
  output logic               o_external_interrupt,
  output logic               o_software_interrupt
);

  typedef enum logic [1:0] {
    REG_PENDING = 2'd0,
    REG_ENABLE  = 2'd1,
    REG_CLAIM   = 2'd2,
    REG_MSIP    = 2'd3
  } reg_sel_e;

  typedef enum logic {
    ST_IDLE,
    ST_ACK
  } bus_state_e;

  bus_state_e         state_q;
  reg_sel_e           reg_sel;
  logic               req_accept;
  logic               wr_req;
  logic               rd_req;

  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] sync_level;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] enable_q;
  logic               msip_q;
  logic [NUM_SRC-1:0] active;

  logic               claim_hit;
  logic [4:0]         claim_idx;
  logic [31:0]        claim_value;
  logic [31:0]        rd_value;

  // Address bits [1:0] are ignored and only the low NUM_SRC data bits matter.
  logic               unused_bits;
  assign unused_bits = ^{i_addr[1:0], i_wdata};

  // ---------------------------------------------------------------------------
  // Request decode: only a strobe seen in IDLE is a transaction.
  // ---------------------------------------------------------------------------
  assign reg_sel    = reg_sel_e'(i_addr[3:2]);
  assign req_accept = (state_q == ST_IDLE) && i_stb;
  assign wr_req     = req_accept && i_wr_en;
  assign rd_req     = req_accept && !i_wr_en;

  // Synchronizer chain per source; stage 0 samples the asynchronous line.
  always_ff @(posedge i_clk) begin
    // NOTE: every clocked assignment is non-blocking so all flops update from
    // pre-edge values; blocking here would collapse the chain into one stage.
    if (!i_rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= i_irq_src;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync_level = sync_q[SYNC_STAGES-1];
  assign active     = pending & enable_q;

  // Lowest-index enabled pending source; downward scan leaves the lowest hit.
  always_comb begin
    // NOTE: defaults first so every path assigns every output -- without them
    // this block would infer latches.
    claim_hit = 1'b0;
    claim_idx = '0;
    for (int n = NUM_SRC - 1; n >= 0; n--) begin
      if (active[n]) begin
        claim_hit = 1'b1;
        claim_idx = 5'(n);
      end
    end
  end

  assign claim_value = claim_hit ? {27'd0, claim_idx + 5'd1} : 32'd0;

`ifdef IRQ_LEVEL_MODE_EN
  // Level mode: PENDING is the synchronized line itself; nothing clears it.
  assign pending = sync_level;
`else
  logic [NUM_SRC-1:0] prev_q;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] clr_mask;
  logic [NUM_SRC-1:0] pending_q;

  assign rise    = sync_level & ~prev_q;
  assign pending = pending_q;

  // Bits cleared this cycle by a W1C write or by a claim read.
  always_comb begin
    clr_mask = '0;
    if (wr_req && (reg_sel == REG_PENDING)) begin
      clr_mask = i_wdata[NUM_SRC-1:0];
    end
    if (rd_req && (reg_sel == REG_CLAIM) && claim_hit) begin
      clr_mask = clr_mask | (NUM_SRC'(1) << claim_idx);
    end
  end

  // Edge history and latched PENDING; a new edge beats a same-cycle clear.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      prev_q    <= '0;
      pending_q <= '0;
    end else begin
      prev_q    <= sync_level;
      pending_q <= (pending_q & ~clr_mask) | rise;
    end
  end
`endif

  // ENABLE and MSIP software-writable registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      enable_q <= '0;
      msip_q   <= 1'b0;
    end else begin
      if (wr_req && (reg_sel == REG_ENABLE)) begin
        enable_q <= i_wdata[NUM_SRC-1:0];
      end
      if (wr_req && (reg_sel == REG_MSIP)) begin
        msip_q <= i_wdata[0];
      end
    end
  end

  // Read-data mux over the register map, zero-extended to 32 bits.
  always_comb begin
    rd_value = '0;
    case (reg_sel)
      REG_PENDING: rd_value = 32'(pending);
      REG_ENABLE:  rd_value = 32'(enable_q);
      REG_CLAIM:   rd_value = claim_value;
      REG_MSIP:    rd_value = {31'd0, msip_q};
      default:     rd_value = '0;
    endcase
  end

  // Two-state bus FSM: capture in IDLE, pulse ack for one cycle in ACK.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      o_ack   <= 1'b0;
      o_rdata <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          o_ack <= 1'b0;
          if (i_stb) begin
            state_q <= ST_ACK;
            o_ack   <= 1'b1;
            o_rdata <= i_wr_en ? 32'd0 : rd_value;
          end
        end
        ST_ACK: begin
          state_q <= ST_IDLE;
          o_ack   <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          o_ack   <= 1'b0;
        end
      endcase
    end
  end

  // Registered interrupt outputs to the core.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_external_interrupt <= 1'b0;
      o_software_interrupt <= 1'b0;
    end else begin
      o_external_interrupt <= |active;
      o_software_interrupt <= msip_q;
    end
  end

endmodule

// File: tb/tb_rv32i_irq_ctrl.sv
// tb_rv32i_irq_ctrl -- self-checking bench for rv32i_irq_ctrl.
// A cycle-level reference model tracks the register file and bus handshake;
// directed scenarios are followed by randomized bus traffic, source activity
// and occasional resets.

module tb_rv32i_irq_ctrl;

  localparam int NUM_SRC = 8;
  localparam int S       = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NUM_SRC-1:0] irq_src;
  logic               stb;
  logic               wr_en;
  logic [3:0]         addr;
  logic [31:0]        wdata;
  logic [31:0]        rdata;
  logic               ack;
  logic               ext_irq;
  logic               sw_irq;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  rv32i_irq_ctrl #(
    .NUM_SRC     (NUM_SRC),
    .SYNC_STAGES (S)
  ) dut (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .i_irq_src            (irq_src),
    .i_stb                (stb),
    .i_wr_en              (wr_en),
    .i_addr               (addr),
    .i_wdata              (wdata),
    .o_rdata              (rdata),
    .o_ack                (ack),
    .o_external_interrupt (ext_irq),
    .o_software_interrupt (sw_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. m_hist[j] is the source value sampled j edges ago, so the
  // synchronized level is the sample from S-1 edges ago.
  // ---------------------------------------------------------------------------
  logic [NUM_SRC-1:0] m_hist [0:S];
  logic [NUM_SRC-1:0] m_pend, m_en;
  logic               m_msip, m_busy, m_ack, m_ext, m_sw;
  logic [31:0]        m_rdata;

  task automatic model_step();
    logic [NUM_SRC-1:0] lvl, prev, pend_eff, masked, clr, new_en;
    logic [31:0]        rv;
    logic               new_msip, accept;
    int                 k;
    if (!rst_n) begin
      for (int j = 0; j <= S; j++) m_hist[j] = '0;
      m_pend = '0; m_en = '0; m_msip = 1'b0; m_busy = 1'b0;
      m_ack = 1'b0; m_ext = 1'b0; m_sw = 1'b0; m_rdata = '0;
      return;
    end
    lvl  = m_hist[S-1];
    prev = m_hist[S];
`ifdef IRQ_LEVEL_MODE_EN
    pend_eff = lvl;
`else
    pend_eff = m_pend;
`endif
    masked = pend_eff & m_en;
    k = -1;
    for (int n = 0; n < NUM_SRC; n++) if (masked[n] && k < 0) k = n;
    clr      = '0;
    rv       = '0;
    new_en   = m_en;
    new_msip = m_msip;
    accept   = !m_busy && stb;
    if (accept) begin
      if (wr_en) begin
        case (addr[3:2])
          2'd0: clr = wdata[NUM_SRC-1:0];
          2'd1: new_en = wdata[NUM_SRC-1:0];
          2'd3: new_msip = wdata[0];
          default: ;
        endcase
      end else begin
        case (addr[3:2])
          2'd0: rv = 32'(pend_eff);
          2'd1: rv = 32'(m_en);
          2'd2: if (k >= 0) begin rv = 32'(k + 1); clr[k] = 1'b1; end
          default: rv = {31'd0, m_msip};
        endcase
      end
      m_rdata = rv;
    end
    m_ext  = |masked;
    m_sw   = m_msip;
    m_en   = new_en;
    m_msip = new_msip;
    m_ack  = accept;
    m_busy = accept;
    for (int j = S; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = irq_src;
`ifdef IRQ_LEVEL_MODE_EN
    m_pend = m_hist[S-1];
`else
    m_pend = (m_pend & ~clr) | (lvl & ~prev);
`endif
  endtask

  always @(posedge clk) model_step();

  // Every cycle the outputs must match the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_ack",   32'(ack),     32'(m_ack));
      check("cyc_rdata", rdata,        m_rdata);
      check("cyc_ext",   32'(ext_irq), 32'(m_ext));
      check("cyc_sw",    32'(sw_irq),  32'(m_sw));
    end
  end

  // One bus transaction; called right after a negedge, returns after one too.
  task automatic bus(input logic wr, input logic [3:0] a, input logic [31:0] d,
                     output logic [31:0] rd);
    stb = 1'b1; wr_en = wr; addr = a; wdata = d;
    @(negedge clk);
    check("bus_ack_hi", 32'(ack), 32'd1);
    rd  = rdata;
    stb = 1'b0;
    @(negedge clk);
    check("bus_ack_lo", 32'(ack), 32'd0);
  endtask

  logic [31:0] rd;

  initial begin
    rst_n = 1'b0; irq_src = '0; stb = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state readback.
    bus(1'b0, 4'h0, 32'd0, rd); check("rst_pending", rd, 32'd0);
    bus(1'b0, 4'h4, 32'd0, rd); check("rst_enable",  rd, 32'd0);
    bus(1'b0, 4'h8, 32'd0, rd); check("rst_claim",   rd, 32'd0);
    bus(1'b0, 4'hC, 32'd0, rd); check("rst_msip",    rd, 32'd0);
    check("rst_ext", 32'(ext_irq), 32'd0);
    check("rst_sw",  32'(sw_irq),  32'd0);

`ifndef IRQ_LEVEL_MODE_EN
    // Single-cycle pulse on source 2: PENDING three edges later, irq one after.
    bus(1'b1, 4'h4, 32'h04, rd);
    irq_src = 8'h04;
    @(negedge clk); irq_src = '0;
    @(negedge clk);
    @(negedge clk); check("t2_ext_early", 32'(ext_irq), 32'd0);
    @(negedge clk); check("t2_ext",       32'(ext_irq), 32'd1);
    bus(1'b0, 4'h0, 32'd0, rd); check("t2_pending", rd, 32'h04);

    // Sources 2 and 5 pending: claims come out lowest first.
    bus(1'b1, 4'h4, 32'h24, rd);
    irq_src = 8'h20;
    @(negedge clk); irq_src = '0;
    repeat (4) @(negedge clk);
    bus(1'b0, 4'h8, 32'd0, rd); check("t3_claim1",  rd, 32'h3);
    bus(1'b0, 4'h0, 32'd0, rd); check("t3_pending", rd, 32'h20);
    bus(1'b0, 4'h8, 32'd0, rd); check("t3_claim2",  rd, 32'h6);
    check("t3_ext_drop", 32'(ext_irq), 32'd0);
    bus(1'b0, 4'h8, 32'd0, rd); check("t3_claim0",  rd, 32'h0);

    // Masked pending source, then enable, then W1C.
    bus(1'b1, 4'h4, 32'h20, rd);
    irq_src = 8'h02;
    @(negedge clk); irq_src = '0;
    repeat (4) @(negedge clk);
    check("t4_masked_ext", 32'(ext_irq), 32'd0);
    bus(1'b0, 4'h0, 32'd0, rd); check("t4_pending", rd, 32'h02);
    bus(1'b1, 4'h4, 32'h02, rd);
    check("t4_ext_on", 32'(ext_irq), 32'd1);
    bus(1'b1, 4'h0, 32'h02, rd);
    bus(1'b0, 4'h0, 32'd0, rd); check("t4_w1c", rd, 32'h0);
    check("t4_ext_off", 32'(ext_irq), 32'd0);

    // W1C on bit 3 lands on the same edge that latches a new edge on bit 3.
    irq_src = 8'h08;
    @(negedge clk);
    @(negedge clk);
    stb = 1'b1; wr_en = 1'b1; addr = 4'h0; wdata = 32'h08;
    @(negedge clk); check("t5_ack", 32'(ack), 32'd1); stb = 1'b0;
    @(negedge clk);
    bus(1'b0, 4'h0, 32'd0, rd); check("t5_set_wins", rd, 32'h08);
    irq_src = '0;
    bus(1'b1, 4'h0, 32'h08, rd);
    bus(1'b0, 4'h0, 32'd0, rd); check("t5_cleared", rd, 32'h0);

    // MSIP, then reset in the same cycle as a request.
    bus(1'b1, 4'hC, 32'h1, rd);
    check("t6_sw", 32'(sw_irq), 32'd1);
    bus(1'b1, 4'h4, 32'hFF, rd);
    irq_src = 8'h01;
    @(negedge clk); irq_src = '0;
    repeat (4) @(negedge clk);
    check("t6_ext", 32'(ext_irq), 32'd1);
    bus(1'b0, 4'hC, 32'd0, rd); check("t6_msip", rd, 32'h1);
    stb = 1'b1; wr_en = 1'b0; addr = 4'h8; rst_n = 1'b0;
    @(negedge clk);
    check("t6_rst_ack",   32'(ack),     32'd0);
    check("t6_rst_ext",   32'(ext_irq), 32'd0);
    check("t6_rst_sw",    32'(sw_irq),  32'd0);
    check("t6_rst_rdata", rdata,        32'd0);
    stb = 1'b0;
    @(negedge clk);
    check("t6_rst_ack2", 32'(ack), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    bus(1'b0, 4'hC, 32'd0, rd); check("t6_msip_rst",   rd, 32'h0);
    bus(1'b0, 4'h4, 32'd0, rd); check("t6_enable_rst", rd, 32'h0);
`endif

    // Randomized traffic checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      rst_n   = ($urandom_range(0, 299) != 0);
      stb     = ($urandom_range(0, 2) == 0);
      wr_en   = 1'($urandom);
      addr    = 4'($urandom);
      wdata   = ($urandom_range(0, 3) == 0) ? $urandom
                                            : 32'(1) << $urandom_range(0, NUM_SRC - 1);
      irq_src = irq_src ^ (NUM_SRC'($urandom) & NUM_SRC'($urandom) & NUM_SRC'($urandom));
      @(negedge clk);
    end
    rst_n = 1'b1; stb = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
